// File: rtl/sv_uart_pkg.sv
// Shared types and helpers for the UART word engine and its byte cores.
package sv_uart_pkg;

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} tx_state_t;

   localparam int WORD_WIDTH = 8;

   // Number of UART bytes that make up one host word.
   function automatic int words_num(input int data_width);
      return data_width / WORD_WIDTH;
   endfunction

   // Byte k of a word in transmission order; the word is right-aligned in 64 bits.
   function automatic logic [7:0] byte_sel(input logic [63:0] word, input int k,
                                           input bit msb_first, input int nbytes);
      int idx;
      idx = msb_first ? (nbytes - 1 - k) : k;
      return word[idx*WORD_WIDTH +: WORD_WIDTH];
   endfunction

   // A divider of zero behaves as one clock per bit.
   function automatic logic [15:0] div_eff(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/sv_uart_rx.sv
// UART byte receiver with an IN_PIPE-stage input synchroniser and mid-bit sampling.
module sv_uart_rx
   import sv_uart_pkg::*;
#(
   parameter int IN_PIPE = 5
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic [15:0] idivider,
   input  logic        irx,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready
);
   logic [IN_PIPE-1:0] sync;
   logic               rx_s;
   logic               active;
   logic [3:0]         bit_idx;
   logic [15:0]        cnt;
   logic [15:0]        div;
   logic [15:0]        half;
   logic [15:0]        target;
   logic [7:0]         shift;

   assign rx_s   = sync[IN_PIPE-1];
   assign div    = div_eff(idivider);
   assign half   = div >> 1;
   // The start bit is sampled half a period in, every later bit one full period on.
   assign target = (bit_idx == 4'd0) ? ((half == 16'd0) ? 16'd0 : half - 16'd1)
                                     : div - 16'd1;

   // Synchronise the line, detect a start bit and shift in the frame.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         sync          <= '1;
         active        <= 1'b0;
         bit_idx       <= '0;
         cnt           <= '0;
         shift         <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         sync <= IN_PIPE'({sync, irx});
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
         if (!active) begin
            if (!rx_s) begin
               active  <= 1'b1;
               cnt     <= '0;
               bit_idx <= '0;
            end
         end else if (cnt == target) begin
            cnt <= '0;
            if (bit_idx == 4'd0) begin
               if (rx_s) active <= 1'b0;      // glitch, not a real start bit
               else      bit_idx <= 4'd1;
            end else if (bit_idx == 4'd9) begin
               active <= 1'b0;
               if (rx_s) begin
                  m_axis_tdata  <= shift;
                  m_axis_tvalid <= 1'b1;
               end
            end else begin
               shift   <= {rx_s, shift[7:1]};
               bit_idx <= bit_idx + 4'd1;
            end
         end else begin
            cnt <= cnt + 16'd1;
         end
      end
   end
endmodule

// File: rtl/sv_uart_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
// s_axis_tuser pulses in the last clock of the final stop bit.
module sv_uart_tx
   import sv_uart_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic        iclk,
   input  logic        irst,
   input  logic [15:0] idivider,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic        s_axis_tuser,
   output logic        otx
);
   localparam int         NB       = 9 + STOP_BITS;
   localparam logic [3:0] LAST_BIT = 4'(NB - 1);

   logic          busy;
   logic [3:0]    bit_idx;
   logic [15:0]   cnt;
   logic [NB-1:0] frame;
   logic [15:0]   div;
   logic          bit_end;

   assign div           = div_eff(idivider);
   assign bit_end       = (cnt == div - 16'd1);
   assign s_axis_tready = ~busy;
   assign s_axis_tuser  = busy && bit_end && (bit_idx == LAST_BIT);
   assign otx           = busy ? frame[0] : 1'b1;

   // Load a frame on handshake, then shift one bit out per bit period.
   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         busy    <= 1'b0;
         bit_idx <= '0;
         cnt     <= '0;
         frame   <= '1;
      end else if (!busy) begin
         if (s_axis_tvalid) begin
            busy    <= 1'b1;
            bit_idx <= '0;
            cnt     <= '0;
            frame   <= {{STOP_BITS{1'b1}}, s_axis_tdata, 1'b0};
         end
      end else if (bit_end) begin
         cnt <= '0;
         if (bit_idx == LAST_BIT) begin
            busy <= 1'b0;
         end else begin
            bit_idx <= bit_idx + 4'd1;
            frame   <= {1'b1, frame[NB-1:1]};
         end
      end else begin
         cnt <= cnt + 16'd1;
      end
   end
endmodule

// File: rtl/sv_uart_word_asm.sv
// RX word assembler: collects bytes into a word, with inter-byte timeout and overflow drop.
module sv_uart_word_asm
   import sv_uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int MSB_FIRST    = 1,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic [15:0]           idivider,
   input  logic [7:0]            byte_data,
   input  logic                  byte_valid,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  otimeout,
   output logic                  ooverflow
);
   localparam int         WORDS_NUM = words_num(DATA_WIDTH);
   localparam logic [3:0] LAST_BYTE = 4'(WORDS_NUM - 1);
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_BITS - 1);

   logic [DATA_WIDTH-1:0] word_reg;
   logic [DATA_WIDTH-1:0] word_next;
   logic [3:0]            byte_cnt;
   logic [7:0]            tick_cnt;
   logic [15:0]           pre_cnt;
   logic [15:0]           div;
   logic                  tick;

   assign div  = div_eff(idivider);
   assign tick = (pre_cnt == div - 16'd1);

   // Partial word with the incoming byte dropped into its slot.
   always_comb begin
      word_next = word_reg;
      for (int i = 0; i < WORDS_NUM; i++) begin
         if (byte_cnt == 4'(i))
            word_next[(MSB_FIRST != 0 ? (WORDS_NUM - 1 - i) : i) * 8 +: 8] = byte_data;
      end
   end

   // Byte collection, output handshake, bit-period prescaler and timeout.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         word_reg      <= '0;
         byte_cnt      <= '0;
         tick_cnt      <= '0;
         pre_cnt       <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         otimeout      <= 1'b0;
         ooverflow     <= 1'b0;
      end else begin
         otimeout  <= 1'b0;
         ooverflow <= 1'b0;
         pre_cnt   <= tick ? 16'd0 : pre_cnt + 16'd1;
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
         if (byte_valid) begin
            // An arriving byte always wins over a coincident timeout.
            tick_cnt <= '0;
            if (byte_cnt == LAST_BYTE) begin
               byte_cnt <= '0;
               if (m_axis_tvalid && !m_axis_tready) begin
                  ooverflow <= 1'b1;
               end else begin
                  m_axis_tdata  <= word_next;
                  m_axis_tvalid <= 1'b1;
               end
            end else begin
               byte_cnt <= byte_cnt + 4'd1;
               word_reg <= word_next;
            end
         end else if (byte_cnt != 4'd0) begin
            if (tick) begin
               if (tick_cnt == TO_LAST) begin
                  tick_cnt <= '0;
                  byte_cnt <= '0;
                  otimeout <= 1'b1;
               end else begin
                  tick_cnt <= tick_cnt + 8'd1;
               end
            end
         end else begin
            tick_cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/sv_uart_word_engine.sv
// AXI-Stream UART word engine: splits TX words into bytes and reassembles RX bytes.
// Optional internal loopback when SV_UART_WORD_ENGINE_LOOPBACK_EN is defined.
module sv_uart_word_engine
   import sv_uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int MSB_FIRST    = 1,
   parameter int STOP_BITS    = 1,
   parameter int IN_PIPE      = 5,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic [15:0]           idivider,
   output logic                  otx,
   input  logic                  irx,
   output logic                  otx_busy,
   output logic                  otimeout,
   output logic                  ooverflow
`ifdef SV_UART_WORD_ENGINE_LOOPBACK_EN
   ,
   input  logic                  iloopback
`endif
);
   localparam int         WORDS_NUM = words_num(DATA_WIDTH);
   localparam logic [3:0] LAST_BYTE = 4'(WORDS_NUM - 1);

   tx_state_t             state;
   logic [3:0]            byte_cnt;
   logic [DATA_WIDTH-1:0] word_reg;
   logic                  irst;
   logic [7:0]            core_tx_data;
   logic                  core_tx_valid;
   logic                  core_tx_ready;
   logic                  core_tx_last;
   logic                  tx_line;
   logic                  rx_line;
   logic                  otx_next;
   logic [7:0]            core_rx_data;
   logic                  core_rx_valid;

   assign irst          = ~irst_n;
   assign core_tx_data  = byte_sel(64'(word_reg), int'(byte_cnt), MSB_FIRST != 0, WORDS_NUM);
   assign core_tx_valid = (state == SEND);
   assign otx_busy      = (state != IDLE);

`ifdef SV_UART_WORD_ENGINE_LOOPBACK_EN
   assign rx_line  = iloopback ? tx_line : irx;
   assign otx_next = iloopback ? 1'b1 : tx_line;
`else
   assign rx_line  = irx;
   assign otx_next = tx_line;
`endif

   // TX word FSM with registered ready and serial output.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         word_reg      <= '0;
         s_axis_tready <= 1'b0;
         otx           <= 1'b1;
      end else begin
         otx <= otx_next;
         case (state)
            IDLE: begin
               if (s_axis_tvalid && s_axis_tready) begin
                  word_reg      <= s_axis_tdata;
                  byte_cnt      <= '0;
                  s_axis_tready <= 1'b0;
                  state         <= SEND;
               end else begin
                  s_axis_tready <= 1'b1;
               end
            end
            SEND: begin
               if (core_tx_ready) begin
                  if (byte_cnt == LAST_BYTE) state <= DRAIN;
                  else                       byte_cnt <= byte_cnt + 4'd1;
               end
            end
            DRAIN: begin
               if (core_tx_last) begin
                  state         <= IDLE;
                  s_axis_tready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sv_uart_tx #(.STOP_BITS(STOP_BITS)) u_tx (
      .iclk          (iclk),
      .irst          (irst),
      .idivider      (idivider),
      .s_axis_tdata  (core_tx_data),
      .s_axis_tvalid (core_tx_valid),
      .s_axis_tready (core_tx_ready),
      .s_axis_tuser  (core_tx_last),
      .otx           (tx_line)
   );

   sv_uart_rx #(.IN_PIPE(IN_PIPE)) u_rx (
      .iclk          (iclk),
      .irst          (irst),
      .idivider      (idivider),
      .irx           (rx_line),
      .m_axis_tdata  (core_rx_data),
      .m_axis_tvalid (core_rx_valid),
      .m_axis_tready (1'b1)
   );

   sv_uart_word_asm #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MSB_FIRST    (MSB_FIRST),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) u_asm (
      .iclk          (iclk),
      .irst_n        (irst_n),
      .idivider      (idivider),
      .byte_data     (core_rx_data),
      .byte_valid    (core_rx_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .otimeout      (otimeout),
      .ooverflow     (ooverflow)
   );
endmodule
